stage_5_byte_serializer: RTL

- Downstream of carry-propagation stage 4.
- Consumes stage 4's per-cycle bundle: up to 5 byte slots, a 3-bit format flag and the last-symbol flag.
- Expands each bundle into an ordered byte stream, one byte per cycle, with valid/ready backpressure toward the bitstream sink.
- Stage 4 cannot stall, so bundles are buffered in an entry FIFO and overflow is reported.

---
 rtl/s5_pkg.sv | 31 +++
 rtl/s5_entry_fifo.sv | 45 ++++
 rtl/stage_5_byte_serializer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/s5_pkg.sv
// s5_pkg: shared types and constants for the stage 5 byte serializer.
// Provides the byte width and FIFO geometry, the format-flag codes,
// the FSM state type and the packed FIFO entry layout.
package s5_pkg;
    localparam int S5_BITSTREAM_WIDTH = 8;
    localparam int S5_FIFO_DEPTH      = 8;
    localparam int S5_FIFO_ADDR_WIDTH = 3;

    localparam logic [2:0] FLAG_NONE      = 3'd0;
    localparam logic [2:0] FLAG_B1        = 3'd1;
    localparam logic [2:0] FLAG_B2        = 3'd2;
    localparam logic [2:0] FLAG_B3        = 3'd3;
    localparam logic [2:0] FLAG_B4        = 3'd4;
    localparam logic [2:0] FLAG_RUN       = 3'd5;
    localparam logic [2:0] FLAG_RUN_TAIL  = 3'd6;
    localparam logic [2:0] FLAG_RUN_2TAIL = 3'd7;

    typedef enum logic [1:0] {S_IDLE, S_SEQ, S_RUN, S_TAIL} s5_state_t;

    typedef logic [S5_BITSTREAM_WIDTH-1:0] s5_byte_t;

    typedef struct packed {
        logic [2:0] flag;
        s5_byte_t   b1;
        s5_byte_t   b2;
        s5_byte_t   b3;
        s5_byte_t   b4;
        s5_byte_t   b5;
        logic       last;
    } s5_entry_t;
endpackage

// File: rtl/s5_entry_fifo.sv
// s5_entry_fifo: synchronous FIFO of s5_entry_t bundles.
// Ports: clk/rst (sync, active-high); push/din write; pop reads dout
// (dout always shows the head entry); full, empty and level status.
// A push while full is only accepted when a pop frees a slot on the same edge.
module s5_entry_fifo
    import s5_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  s5_entry_t                   din,
    input  logic                        pop,
    output s5_entry_t                   dout,
    output logic                        full,
    output logic                        empty,
    output logic [S5_FIFO_ADDR_WIDTH:0] level
);
    s5_entry_t                     mem [S5_FIFO_DEPTH];
    logic [S5_FIFO_ADDR_WIDTH-1:0] wptr;
    logic [S5_FIFO_ADDR_WIDTH-1:0] rptr;
    logic                          wr;
    logic                          rd;

    assign full  = level == (S5_FIFO_ADDR_WIDTH+1)'(S5_FIFO_DEPTH);
    assign empty = level == '0;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign dout  = mem[rptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            level <= level + (S5_FIFO_ADDR_WIDTH+1)'(wr) - (S5_FIFO_ADDR_WIDTH+1)'(rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem[wptr] <= din;
    end
endmodule

// File: rtl/stage_5_byte_serializer.sv
// stage_5_byte_serializer: expands stage 4 bundles into a valid/ready byte stream.
// Inputs: s5_clk, s5_reset (sync, active-high), five byte slots, 3-bit format
// flag, last-bundle flag, sink ready. Outputs: out_byte/out_valid/out_last
// stream, out_done frame pulse, sticky out_error overflow, out_fifo_level.
module stage_5_byte_serializer
    import s5_pkg::*;
(
    input  logic                          s5_clk,
    input  logic                          s5_reset,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_1,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_2,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_3,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_4,
    input  logic [S5_BITSTREAM_WIDTH-1:0] in_carry_bit_5,
    input  logic [2:0]                    in_carry_flag_bitstream,
    input  logic                          in_flag_last,
    input  logic                          in_sink_ready,
    output logic [S5_BITSTREAM_WIDTH-1:0] out_byte,
    output logic                          out_valid,
    output logic                          out_last,
    output logic                          out_done,
    output logic                          out_error,
    output logic [S5_FIFO_ADDR_WIDTH:0]   out_fifo_level
);
    s5_state_t state, n_state;
    s5_entry_t cur, e, din, fifo_dout;
    logic [1:0] idx, n_idx;
    logic [7:0] cnt, n_cnt;
    s5_byte_t   n_byte;
    logic       step, ending, push, pop, full, empty, n_final, n_done;

    assign push = in_carry_flag_bitstream != FLAG_NONE || in_flag_last;
    assign din  = '{in_carry_flag_bitstream, in_carry_bit_1, in_carry_bit_2,
                    in_carry_bit_3, in_carry_bit_4, in_carry_bit_5, in_flag_last};
    // The output register moves whenever it is empty or its byte is being taken.
    assign step = ~out_valid | in_sink_ready;

    s5_entry_fifo u_fifo (
        .clk   (s5_clk),
        .rst   (s5_reset),
        .push  (push),
        .din   (din),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (full),
        .empty (empty),
        .level (out_fifo_level)
    );

    // Position following the byte currently shown; ending means the entry is used up.
    always_comb begin
        n_state = state;
        n_idx   = idx;
        n_cnt   = cnt;
        ending  = 1'b0;
        case (state)
            S_IDLE: ending = 1'b1;
            S_SEQ: begin
                if (cur.flag < FLAG_RUN) begin
                    if (idx == cur.flag[1:0] - 2'd1) ending = 1'b1;
                    else n_idx = idx + 2'd1;
                end else if (cur.b3 != '0) begin
                    n_state = S_RUN;
                    n_cnt   = cur.b3 - 8'd1;
                end else if (cur.flag != FLAG_RUN) begin
                    n_state = S_TAIL;
                    n_idx   = '0;
                end else ending = 1'b1;
            end
            S_RUN: begin
                if (cnt != '0) n_cnt = cnt - 8'd1;
                else if (cur.flag != FLAG_RUN) begin
                    n_state = S_TAIL;
                    n_idx   = '0;
                end else ending = 1'b1;
            end
            S_TAIL: begin
                if (idx == 2'd0 && cur.flag == FLAG_RUN_2TAIL) n_idx = 2'd1;
                else ending = 1'b1;
            end
        endcase
        pop = step & ending & ~empty;
        e   = pop ? fifo_dout : cur;
        if (ending) begin
            n_state = (pop && fifo_dout.flag != FLAG_NONE) ? S_SEQ : S_IDLE;
            n_idx   = '0;
        end
        n_byte  = n_state == S_SEQ  ? (n_idx == 2'd0 ? e.b1 : n_idx == 2'd1 ? e.b2 :
                                       n_idx == 2'd2 ? e.b3 : e.b4) :
                  n_state == S_RUN  ? e.b2 :
                  n_state == S_TAIL ? (n_idx[0] ? e.b5 : e.b4) : '0;
        n_final = n_state == S_SEQ  ? (e.flag < FLAG_RUN ? n_idx == e.flag[1:0] - 2'd1 :
                                       e.flag == FLAG_RUN && e.b3 == '0) :
                  n_state == S_RUN  ? (n_cnt == '0 && e.flag == FLAG_RUN) :
                  n_state == S_TAIL ? (n_idx[0] || e.flag == FLAG_RUN_TAIL) : 1'b0;
        // Done follows either the final byte of a last entry or a popped marker.
        n_done  = ending && ((state != S_IDLE && cur.last) ||
                             (pop && fifo_dout.flag == FLAG_NONE && fifo_dout.last));
    end

    always_ff @(posedge s5_clk) begin
        if (s5_reset) begin
            state     <= S_IDLE;
            cur       <= '0;
            idx       <= '0;
            cnt       <= '0;
            out_byte  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_done  <= 1'b0;
            out_error <= 1'b0;
        end else begin
            out_error <= out_error | (push & full & ~pop);
            out_done  <= step & n_done;
            if (step) begin
                state     <= n_state;
                cur       <= e;
                idx       <= n_idx;
                cnt       <= n_cnt;
                out_byte  <= n_byte;
                out_valid <= n_state != S_IDLE;
                out_last  <= n_final & e.last;
            end
        end
    end
endmodule
